// File: rtl/alarm_trigger.sv
// Alarm sequencing: arm, ring, snooze (with midnight wrap), stop and auto-timeout; drives buzzer pattern.
// State | meaning: IDLE disabled | ARMED waiting for alarm | RINGING buzzer on | SNOOZE waiting for snooze target
module alarm_trigger #(
    parameter int MAX_COUNT         = 8640000,
    parameter int SNOOZE_HUNDREDTHS = 54000,
    parameter int RING_TIMEOUT      = 6000,
    parameter int MAX_SNOOZES       = 3,
    parameter int BEEP_HALF_PERIOD  = 2500000
) (
    input  logic        i_Clk_5MHz,
    input  logic        i_Reset,
    input  logic [23:0] i_Time_Stamp,
    input  logic [23:0] i_Alarm_Time_Stamp,
    input  logic        i_Alarm_Enable,
    input  logic        i_Snooze,
    input  logic        i_Stop,
    output logic        o_Alarm_Active,
    output logic        o_Buzzer,
    output logic        o_Snoozing,
    output logic [3:0]  o_Snooze_Count,
    output logic [1:0]  o_State
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    localparam int RW = $clog2(RING_TIMEOUT + 1);
    localparam int BW = $clog2(BEEP_HALF_PERIOD + 1);
    localparam logic [RW-1:0] RING_LOAD    = RW'(RING_TIMEOUT);
    localparam logic [BW-1:0] BEEP_LOAD    = BW'(BEEP_HALF_PERIOD - 1);
    localparam logic [24:0]   SNOOZE_ADD   = 25'(SNOOZE_HUNDREDTHS);
    localparam logic [24:0]   DAY_MOD      = 25'(MAX_COUNT);
    localparam logic [3:0]    SNOOZE_LIMIT = 4'(MAX_SNOOZES);

    state_t          state_q, state_d;
    logic [3:0]      count_q, count_d;
    logic [23:0]     target_q, target_d;
    logic [23:0]     prev_stamp_q;
    logic            alarm_eq_q, snooze_eq_q;
    logic [RW-1:0]   ring_q, ring_d;
    logic [BW-1:0]   beep_q, beep_d;
    logic            buzz_q, buzz_d;
    logic            active_q, snoozing_q;

    logic            alarm_eq, snooze_eq, alarm_match, snooze_match;
    logic            stamp_tick, ring_timeout, enter_ring;
    logic [24:0]     snooze_sum;

    assign alarm_eq     = (i_Alarm_Time_Stamp == i_Time_Stamp);
    assign snooze_eq    = (target_q == i_Time_Stamp);
    assign alarm_match  = alarm_eq & ~alarm_eq_q;
    assign snooze_match = snooze_eq & ~snooze_eq_q;
    assign stamp_tick   = (i_Time_Stamp != prev_stamp_q);
    assign ring_timeout = (ring_q == '0);
    assign snooze_sum   = {1'b0, i_Time_Stamp} + SNOOZE_ADD;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        target_d   = target_q;
        enter_ring = 1'b0;
        if (!i_Alarm_Enable) begin
            state_d  = IDLE;
            count_d  = '0;
            target_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (alarm_match) begin
                        state_d    = RINGING;
                        enter_ring = 1'b1;
                    end
                end
                RINGING: begin
                    if (i_Stop || ring_timeout) begin
                        state_d = ARMED;
                        count_d = '0;
                    end else if (i_Snooze && (count_q < SNOOZE_LIMIT)) begin
                        state_d  = SNOOZE;
                        count_d  = count_q + 4'd1;
                        target_d = (snooze_sum >= DAY_MOD) ? 24'(snooze_sum - DAY_MOD)
                                                           : 24'(snooze_sum);
                    end
                end
                SNOOZE: begin
                    if (i_Stop) begin
                        state_d = ARMED;
                        count_d = '0;
                    end else if (snooze_match) begin
                        state_d    = RINGING;
                        enter_ring = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Ring timer and beep timer are down-counters, live only while ringing.
    always_comb begin
        ring_d = '0;
        beep_d = '0;
        buzz_d = 1'b0;
        if (enter_ring) begin
            ring_d = RING_LOAD;
            beep_d = BEEP_LOAD;
            buzz_d = 1'b1;
        end else if (state_d == RINGING) begin
            ring_d = (stamp_tick && !ring_timeout) ? ring_q - 1'b1 : ring_q;
            if (beep_q == '0) begin
                beep_d = BEEP_LOAD;
                buzz_d = ~buzz_q;
            end else begin
                beep_d = beep_q - 1'b1;
                buzz_d = buzz_q;
            end
        end
    end

    always_ff @(posedge i_Clk_5MHz) begin
        if (i_Reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            target_q     <= '0;
            prev_stamp_q <= '0;
            alarm_eq_q   <= 1'b0;
            snooze_eq_q  <= 1'b0;
            ring_q       <= '0;
            beep_q       <= '0;
            buzz_q       <= 1'b0;
            active_q     <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            target_q     <= target_d;
            prev_stamp_q <= i_Time_Stamp;
            alarm_eq_q   <= alarm_eq;
            snooze_eq_q  <= snooze_eq;
            ring_q       <= ring_d;
            beep_q       <= beep_d;
            buzz_q       <= buzz_d;
            active_q     <= (state_d == RINGING);
            snoozing_q   <= (state_d == SNOOZE);
        end
    end

    assign o_State        = state_q;
    assign o_Snooze_Count = count_q;
    assign o_Buzzer       = buzz_q;
    assign o_Alarm_Active = active_q;
    assign o_Snoozing     = snoozing_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: ring/stop, snooze wrap, snooze limit, timeout, priority, reset.
module tb_alarm_trigger;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] ts;
    logic [23:0] alarm;
    logic        en;
    logic        snz;
    logic        stp;
    logic        o_Alarm_Active;
    logic        o_Buzzer;
    logic        o_Snoozing;
    logic [3:0]  o_Snooze_Count;
    logic [1:0]  o_State;

    int checks = 0;
    int errors = 0;

    alarm_trigger #(
        .MAX_COUNT(8640000),
        .SNOOZE_HUNDREDTHS(500),
        .RING_TIMEOUT(200),
        .MAX_SNOOZES(3),
        .BEEP_HALF_PERIOD(4)
    ) dut (
        .i_Clk_5MHz(clk),
        .i_Reset(rst),
        .i_Time_Stamp(ts),
        .i_Alarm_Time_Stamp(alarm),
        .i_Alarm_Enable(en),
        .i_Snooze(snz),
        .i_Stop(stp),
        .o_Alarm_Active(o_Alarm_Active),
        .o_Buzzer(o_Buzzer),
        .o_Snoozing(o_Snoozing),
        .o_Snooze_Count(o_Snooze_Count),
        .o_State(o_State)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_stamp(input logic [23:0] v, input int n);
        ts = v;
        step(n);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; snz = 1'b0; stp = 1'b0; ts = 24'd0; alarm = 24'd1000;
        step(2);
        checks++; if (o_State !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", o_State); end
        checks++; if (o_Alarm_Active !== 1'b0) begin errors++; $display("FAIL reset_active got %0b want 0", o_Alarm_Active); end
        checks++; if (o_Buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer got %0b want 0", o_Buzzer); end
        checks++; if (o_Snoozing !== 1'b0) begin errors++; $display("FAIL reset_snoozing got %0b want 0", o_Snoozing); end
        checks++; if (o_Snooze_Count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_Snooze_Count); end
        rst = 1'b0; en = 1'b1; ts = 24'd990;
        step(1);
        checks++; if (o_State !== 2'd1) begin errors++; $display("FAIL arm_state got %0d want 1", o_State); end
    endtask

    task automatic test_basic_ring();
        for (int t = 990; t < 1000; t++) set_stamp(24'(t), 10);
        checks++; if (o_Alarm_Active !== 1'b0) begin errors++; $display("FAIL pre_ring_active got %0b want 0", o_Alarm_Active); end
        set_stamp(24'd1000, 1);
        checks++; if (o_Alarm_Active !== 1'b1) begin errors++; $display("FAIL ring_active got %0b want 1", o_Alarm_Active); end
        checks++; if (o_State !== 2'd2) begin errors++; $display("FAIL ring_state got %0d want 2", o_State); end
        checks++; if (o_Buzzer !== 1'b1) begin errors++; $display("FAIL buzz_entry got %0b want 1", o_Buzzer); end
        step(3);
        checks++; if (o_Buzzer !== 1'b1) begin errors++; $display("FAIL buzz_e3 got %0b want 1", o_Buzzer); end
        step(1);
        checks++; if (o_Buzzer !== 1'b0) begin errors++; $display("FAIL buzz_e4 got %0b want 0", o_Buzzer); end
        step(3);
        checks++; if (o_Buzzer !== 1'b0) begin errors++; $display("FAIL buzz_e7 got %0b want 0", o_Buzzer); end
        step(1);
        checks++; if (o_Buzzer !== 1'b1) begin errors++; $display("FAIL buzz_e8 got %0b want 1", o_Buzzer); end
        stp = 1'b1; step(1); stp = 1'b0;
        checks++; if (o_State !== 2'd1) begin errors++; $display("FAIL stop_state got %0d want 1", o_State); end
        checks++; if (o_Buzzer !== 1'b0) begin errors++; $display("FAIL stop_buzzer got %0b want 0", o_Buzzer); end
        step(20);
        checks++; if (o_State !== 2'd1) begin errors++; $display("FAIL no_retrigger got %0d want 1", o_State); end
    endtask

    task automatic test_snooze_wrap();
        alarm = 24'd8639800;
        set_stamp(24'd8639799, 10);
        set_stamp(24'd8639800, 1);
        checks++; if (o_State !== 2'd2) begin errors++; $display("FAIL wrap_ring got %0d want 2", o_State); end
        snz = 1'b1; step(1); snz = 1'b0;
        checks++; if (o_State !== 2'd3) begin errors++; $display("FAIL wrap_snooze_state got %0d want 3", o_State); end
        checks++; if (o_Snoozing !== 1'b1) begin errors++; $display("FAIL wrap_snoozing got %0b want 1", o_Snoozing); end
        checks++; if (o_Snooze_Count !== 4'd1) begin errors++; $display("FAIL wrap_count got %0d want 1", o_Snooze_Count); end
        checks++; if (o_Buzzer !== 1'b0) begin errors++; $display("FAIL wrap_buzzer got %0b want 0", o_Buzzer); end
        set_stamp(24'd8639999, 10);
        set_stamp(24'd0, 10);
        set_stamp(24'd299, 10);
        checks++; if (o_State !== 2'd3) begin errors++; $display("FAIL wrap_early got %0d want 3", o_State); end
        set_stamp(24'd300, 1);
        checks++; if (o_Alarm_Active !== 1'b1) begin errors++; $display("FAIL wrap_rering got %0b want 1", o_Alarm_Active); end
        checks++; if (o_Snooze_Count !== 4'd1) begin errors++; $display("FAIL wrap_count_kept got %0d want 1", o_Snooze_Count); end
    endtask

    task automatic test_snooze_limit();
        // currently ringing at stamp 300 with one snooze used
        snz = 1'b1; step(1); snz = 1'b0;
        set_stamp(24'd799, 10);
        set_stamp(24'd800, 1);
        checks++; if (o_Snooze_Count !== 4'd2 || o_State !== 2'd2) begin errors++; $display("FAIL limit_second got cnt %0d st %0d want 2 2", o_Snooze_Count, o_State); end
        snz = 1'b1; step(1); snz = 1'b0;
        set_stamp(24'd1299, 10);
        set_stamp(24'd1300, 1);
        checks++; if (o_Snooze_Count !== 4'd3 || o_State !== 2'd2) begin errors++; $display("FAIL limit_third got cnt %0d st %0d want 3 2", o_Snooze_Count, o_State); end
        snz = 1'b1; step(1); snz = 1'b0;
        step(1);
        checks++; if (o_State !== 2'd2) begin errors++; $display("FAIL limit_state got %0d want 2", o_State); end
        checks++; if (o_Snooze_Count !== 4'd3) begin errors++; $display("FAIL limit_count got %0d want 3", o_Snooze_Count); end
        stp = 1'b1; step(1); stp = 1'b0;
        checks++; if (o_Snooze_Count !== 4'd0 || o_State !== 2'd1) begin errors++; $display("FAIL limit_stop got cnt %0d st %0d want 0 1", o_Snooze_Count, o_State); end
    endtask

    task automatic test_timeout();
        alarm = 24'd5000;
        set_stamp(24'd4999, 10);
        set_stamp(24'd5000, 1);
        snz = 1'b1; step(1); snz = 1'b0;
        set_stamp(24'd5499, 10);
        set_stamp(24'd5500, 1);
        checks++; if (o_State !== 2'd2 || o_Snooze_Count !== 4'd1) begin errors++; $display("FAIL to_ring got st %0d cnt %0d want 2 1", o_State, o_Snooze_Count); end
        for (int i = 1; i < 200; i++) set_stamp(24'(5500 + i), 10);
        set_stamp(24'd5700, 1);
        checks++; if (o_State !== 2'd2) begin errors++; $display("FAIL to_early got %0d want 2", o_State); end
        step(1);
        checks++; if (o_State !== 2'd1) begin errors++; $display("FAIL to_state got %0d want 1", o_State); end
        checks++; if (o_Buzzer !== 1'b0 || o_Alarm_Active !== 1'b0) begin errors++; $display("FAIL to_outputs got buz %0b act %0b want 0 0", o_Buzzer, o_Alarm_Active); end
        checks++; if (o_Snooze_Count !== 4'd0) begin errors++; $display("FAIL to_count got %0d want 0", o_Snooze_Count); end
    endtask

    task automatic test_priority_disable();
        alarm = 24'd6000;
        set_stamp(24'd5999, 10);
        set_stamp(24'd6000, 1);
        stp = 1'b1; snz = 1'b1; step(1); stp = 1'b0; snz = 1'b0;
        checks++; if (o_State !== 2'd1 || o_Snooze_Count !== 4'd0) begin errors++; $display("FAIL prio_stop got st %0d cnt %0d want 1 0", o_State, o_Snooze_Count); end
        alarm = 24'd7000;
        set_stamp(24'd6999, 10);
        set_stamp(24'd7000, 1);
        snz = 1'b1; step(1); snz = 1'b0;
        checks++; if (o_State !== 2'd3) begin errors++; $display("FAIL dis_snooze got %0d want 3", o_State); end
        en = 1'b0; step(1);
        checks++; if (o_State !== 2'd0 || o_Snoozing !== 1'b0 || o_Snooze_Count !== 4'd0) begin errors++; $display("FAIL dis_idle got st %0d snz %0b cnt %0d want 0 0 0", o_State, o_Snoozing, o_Snooze_Count); end
        en = 1'b1; step(1);
        checks++; if (o_State !== 2'd1) begin errors++; $display("FAIL dis_rearm got %0d want 1", o_State); end
        set_stamp(24'd7499, 10);
        set_stamp(24'd7500, 6);
        checks++; if (o_State !== 2'd1 || o_Alarm_Active !== 1'b0) begin errors++; $display("FAIL dis_old_target got st %0d act %0b want 1 0", o_State, o_Alarm_Active); end
    endtask

    task automatic test_reset_mid_ring();
        alarm = 24'd9000;
        set_stamp(24'd8999, 10);
        set_stamp(24'd9000, 1);
        checks++; if (o_State !== 2'd2) begin errors++; $display("FAIL rr_ring got %0d want 2", o_State); end
        step(2);
        rst = 1'b1; step(1); rst = 1'b0;
        checks++; if (o_State !== 2'd0 || o_Alarm_Active !== 1'b0 || o_Buzzer !== 1'b0 || o_Snoozing !== 1'b0 || o_Snooze_Count !== 4'd0)
            begin errors++; $display("FAIL rr_reset got st %0d act %0b buz %0b snz %0b cnt %0d want 0 0 0 0 0", o_State, o_Alarm_Active, o_Buzzer, o_Snoozing, o_Snooze_Count); end
        step(1);
        checks++; if (o_State !== 2'd1) begin errors++; $display("FAIL rr_armed got %0d want 1", o_State); end
        step(20);
        checks++; if (o_State !== 2'd1 || o_Alarm_Active !== 1'b0) begin errors++; $display("FAIL rr_no_ring got st %0d act %0b want 1 0", o_State, o_Alarm_Active); end
        set_stamp(24'd9001, 10);
        set_stamp(24'd9000, 1);
        checks++; if (o_State !== 2'd2 || o_Buzzer !== 1'b1) begin errors++; $display("FAIL rr_rising got st %0d buz %0b want 2 1", o_State, o_Buzzer); end
    endtask

    initial begin
        test_reset();
        test_basic_ring();
        test_snooze_wrap();
        test_snooze_limit();
        test_timeout();
        test_priority_disable();
        test_reset_mid_ring();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
